// File: rtl/gru_pkg.sv
// Shared definitions for the GRU timestep sequencer: FSM state codes,
// FP32 constants and the default word width.
package gru_pkg;

  localparam int GRU_DATA_WIDTH = 32;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

  localparam int STATE_W = 4;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_P0_RUN    = 4'd1;
  localparam logic [3:0] S_P0_REL    = 4'd2;
  localparam logic [3:0] S_RMUL_LD   = 4'd3;
  localparam logic [3:0] S_RMUL_WAIT = 4'd4;
  localparam logic [3:0] S_RMUL_ACK  = 4'd5;
  localparam logic [3:0] S_P1_RUN    = 4'd6;
  localparam logic [3:0] S_P1_REL    = 4'd7;
  localparam logic [3:0] S_COMMIT    = 4'd8;

endpackage

// File: rtl/gru_step_sequencer_mul.sv
// FP32 multiplier with a level start/done handshake: done rises one cycle after
// start and stays high until start falls. Denormals flush to zero, round-to-nearest-even.
module gru_step_sequencer_mul
  import gru_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [31:0] w,
  input  logic [31:0] x,
  output logic        done,
  output logic [31:0] mult_result
);

  logic               sign;
  logic [7:0]         ea, eb;
  logic [47:0]        mant_a, mant_b, prod;
  logic [22:0]        frac;
  logic               guard, sticky;
  logic [23:0]        rnd;
  logic signed [9:0]  exp_n;
  logic [31:0]        prod_fp;
  logic               done_q, done_d;
  logic [31:0]        res_q, res_d;

  always_comb begin
    sign   = w[31] ^ x[31];
    ea     = w[30:23];
    eb     = x[30:23];
    mant_a = {24'd0, 1'b1, w[22:0]};
    mant_b = {24'd0, 1'b1, x[22:0]};
    prod   = mant_a * mant_b;
    if (prod[47]) begin
      frac   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
      exp_n  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd126;
    end else begin
      frac   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
      exp_n  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
    end
    rnd = {1'b0, frac} + {23'd0, guard & (sticky | frac[0])};
    // A rounding carry out of the mantissa leaves rnd[22:0] == 0 and bumps the exponent.
    if (rnd[23]) exp_n = exp_n + 10'sd1;

    if (((ea == 8'hFF) && (w[22:0] != 23'd0)) || ((eb == 8'hFF) && (x[22:0] != 23'd0)) ||
        ((ea == 8'hFF) && (eb == 8'h00)) || ((eb == 8'hFF) && (ea == 8'h00)))
      prod_fp = 32'h7FC0_0000;
    else if ((ea == 8'hFF) || (eb == 8'hFF) || (exp_n >= 10'sd255))
      prod_fp = {sign, 8'hFF, 23'd0};
    else if ((ea == 8'h00) || (eb == 8'h00) || (exp_n <= 10'sd0))
      prod_fp = {sign, FP_ZERO[30:0]};
    else
      prod_fp = {sign, exp_n[7:0], rnd[22:0]};

    done_d = start;
    res_d  = (start && !done_q) ? prod_fp : res_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      done_q <= 1'b0;
      res_q  <= '0;
    end else begin
      done_q <= done_d;
      res_q  <= res_d;
    end
  end

  assign done        = done_q;
  assign mult_result = res_q;

endmodule

// File: rtl/gru_step_sequencer.sv
// One GRU timestep over GRU_UNITS cells: reset-gate pass, r*h_prev on a shared
// multiplier, candidate/update pass, then commit of the hidden-state register.
module gru_step_sequencer
  import gru_pkg::*;
#(
  parameter int DATA_WIDTH     = GRU_DATA_WIDTH,
  parameter int GRU_UNITS      = 3,
  parameter int INPUT_FEATURES = 3,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                i_start,
  input  logic                                i_clear_hidden,
  input  logic [INPUT_FEATURES*DATA_WIDTH-1:0] i_input_vector_flat,
  output logic [INPUT_FEATURES*DATA_WIDTH-1:0] o_input_vector_flat,
  output logic                                o_cell_start,
  output logic                                o_cell_phase,
  input  logic [GRU_UNITS-1:0]                i_cell_done,
  input  logic [GRU_UNITS*DATA_WIDTH-1:0]     i_cell_out_flat,
  output logic [GRU_UNITS*DATA_WIDTH-1:0]     o_prev_hidden_flat,
  output logic [GRU_UNITS*DATA_WIDTH-1:0]     o_r_mod_hidden_flat,
  output logic [GRU_UNITS*DATA_WIDTH-1:0]     o_hidden_state_flat,
  output logic                                o_busy,
  output logic                                o_done,
  output logic                                o_error,
  output logic [15:0]                         o_step_count,
  output logic [STATE_W-1:0]                  o_dbg_state
);

  localparam int IDX_W = $clog2(GRU_UNITS) + 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef logic [GRU_UNITS-1:0][DATA_WIDTH-1:0] vec_t;

  logic [STATE_W-1:0]                   state_q, state_d;
  logic [TMR_W-1:0]                     timer_q, timer_d;
  logic [IDX_W-1:0]                     idx_q, idx_d;
  logic [GRU_UNITS-1:0]                 mask_q, mask_d;
  vec_t                                 r_q, r_d, h_new_q, h_new_d;
  vec_t                                 hidden_q, hidden_d, r_mod_q, r_mod_d;
  logic [INPUT_FEATURES*DATA_WIDTH-1:0] x_q, x_d;
  logic [DATA_WIDTH-1:0]                mul_w_q, mul_w_d, mul_x_q, mul_x_d;
  logic                                 error_q, error_d;
  logic [15:0]                          step_q, step_d;
  vec_t                                 cell_out;
  logic                                 waiting;
  logic                                 mul_start, mul_done;
  logic [DATA_WIDTH-1:0]                mul_result;

  // Both handshakes are level based: start is held until every done is seen
  // high, then dropped, and the next request waits for every done to fall.
  assign cell_out  = i_cell_out_flat;
  assign waiting   = state_q inside {S_P0_RUN, S_P0_REL, S_RMUL_WAIT, S_RMUL_ACK, S_P1_RUN, S_P1_REL};
  assign mul_start = (state_q == S_RMUL_WAIT);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mask_d   = mask_q;
    r_d      = r_q;
    h_new_d  = h_new_q;
    hidden_d = hidden_q;
    r_mod_d  = r_mod_q;
    x_d      = x_q;
    mul_w_d  = mul_w_q;
    mul_x_d  = mul_x_q;
    error_d  = error_q;
    step_d   = step_q;
    case (state_q)
      S_IDLE: begin
        if (i_clear_hidden) begin
          hidden_d = '0;
          step_d   = '0;
        end else if (i_start) begin
          x_d     = i_input_vector_flat;
          r_d     = '0;
          mask_d  = '0;
          error_d = 1'b0;
          idx_d   = '0;
          state_d = S_P0_RUN;
        end
      end
      S_P0_RUN, S_P1_RUN: begin
        mask_d = mask_q | i_cell_done;
        for (int i = 0; i < GRU_UNITS; i++) begin
          if (i_cell_done[i] && !mask_q[i]) begin
            if (state_q == S_P0_RUN) r_d[i] = cell_out[i];
            else                     h_new_d[i] = cell_out[i];
          end
        end
        if (&mask_d) state_d = (state_q == S_P0_RUN) ? S_P0_REL : S_P1_REL;
      end
      S_P0_REL, S_P1_REL: begin
        if (i_cell_done == '0) begin
          mask_d  = '0;
          state_d = (state_q == S_P0_REL) ? S_RMUL_LD : S_COMMIT;
        end
      end
      S_RMUL_LD: begin
        for (int i = 0; i < GRU_UNITS; i++) begin
          if (idx_q == IDX_W'(i)) begin
            mul_w_d = r_q[i];
            mul_x_d = hidden_q[i];
          end
        end
        state_d = S_RMUL_WAIT;
      end
      S_RMUL_WAIT: begin
        if (mul_done) begin
          for (int i = 0; i < GRU_UNITS; i++)
            if (idx_q == IDX_W'(i)) r_mod_d[i] = mul_result;
          state_d = S_RMUL_ACK;
        end
      end
      S_RMUL_ACK: begin
        if (!mul_done) begin
          if (idx_q == IDX_W'(GRU_UNITS - 1)) begin
            idx_d   = '0;
            state_d = S_P1_RUN;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_RMUL_LD;
          end
        end
      end
      S_COMMIT: begin
        hidden_d = h_new_q;
        step_d   = step_q + 16'd1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abandoning a step keeps the committed hidden state; only the flag is raised.
    if (waiting && (state_d == state_q) && (timer_q == TMR_W'(TIMEOUT_CYCLES - 1))) begin
      error_d = 1'b1;
      state_d = S_IDLE;
    end
    timer_d = (waiting && (state_d == state_q)) ? timer_q + 1'b1 : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      idx_q    <= '0;
      mask_q   <= '0;
      r_q      <= '0;
      h_new_q  <= '0;
      hidden_q <= '0;
      r_mod_q  <= '0;
      x_q      <= '0;
      mul_w_q  <= '0;
      mul_x_q  <= '0;
      error_q  <= 1'b0;
      step_q   <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      idx_q    <= idx_d;
      mask_q   <= mask_d;
      r_q      <= r_d;
      h_new_q  <= h_new_d;
      hidden_q <= hidden_d;
      r_mod_q  <= r_mod_d;
      x_q      <= x_d;
      mul_w_q  <= mul_w_d;
      mul_x_q  <= mul_x_d;
      error_q  <= error_d;
      step_q   <= step_d;
    end
  end

  gru_step_sequencer_mul u_mul (
    .clk         (clk),
    .rstn        (rstn),
    .start       (mul_start),
    .w           (mul_w_q),
    .x           (mul_x_q),
    .done        (mul_done),
    .mult_result (mul_result)
  );

  assign o_input_vector_flat = x_q;
  assign o_cell_start        = (state_q == S_P0_RUN) || (state_q == S_P1_RUN);
  assign o_cell_phase        = (state_q == S_P1_RUN) || (state_q == S_P1_REL);
  assign o_prev_hidden_flat  = hidden_q;
  assign o_hidden_state_flat = hidden_q;
  assign o_r_mod_hidden_flat = r_mod_q;
  assign o_busy              = (state_q != S_IDLE);
  assign o_done              = (state_q == S_COMMIT);
  assign o_error             = error_q;
  assign o_step_count        = step_q;
  assign o_dbg_state         = state_q;

endmodule

// File: tb/tb_gru_step_sequencer.sv
// Bench for gru_step_sequencer: reactive cell stubs, random FP32 operands and a
// real-arithmetic reference for r*h_prev, hidden commit and step counting.
module tb_gru_step_sequencer;
  import gru_pkg::*;

  localparam int U  = 3;
  localparam int F  = 3;
  localparam int DW = 32;

  logic                 clk;
  logic                 rstn;
  logic                 i_start;
  logic                 i_clear_hidden;
  logic [F*DW-1:0]      in_vec;
  logic [F*DW-1:0]      o_in_vec;
  logic                 o_cell_start;
  logic                 o_cell_phase;
  logic [U-1:0]         cell_done = '0;
  logic [U-1:0][DW-1:0] cell_word = '0;
  logic [U-1:0][DW-1:0] prev_w, r_mod_w, hidden_w;
  logic                 o_busy, o_done, o_error;
  logic [15:0]          o_step_count;
  logic [STATE_W-1:0]   o_dbg_state;

  gru_step_sequencer dut (
    .clk                 (clk),
    .rstn                (rstn),
    .i_start             (i_start),
    .i_clear_hidden      (i_clear_hidden),
    .i_input_vector_flat (in_vec),
    .o_input_vector_flat (o_in_vec),
    .o_cell_start        (o_cell_start),
    .o_cell_phase        (o_cell_phase),
    .i_cell_done         (cell_done),
    .i_cell_out_flat     (cell_word),
    .o_prev_hidden_flat  (prev_w),
    .o_r_mod_hidden_flat (r_mod_w),
    .o_hidden_state_flat (hidden_w),
    .o_busy              (o_busy),
    .o_done              (o_done),
    .o_error             (o_error),
    .o_step_count        (o_step_count),
    .o_dbg_state         (o_dbg_state)
  );

  // ---------------- clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] h_model[U];
  logic [15:0]   step_model;
  int            checks_total  = 0;
  int            checks_passed = 0;
  int            done_pulses   = 0;
  int            done_exp      = 0;
  int            p0_cycles     = 0;
  int            p0_base;

  // ---------------- cell stubs
  logic [DW-1:0] stub_r[U];
  logic [DW-1:0] stub_h[U];
  int            stub_dly[U];
  int            stub_lag[U];
  bit            stub_never[U];
  int            run_cnt[U];
  int            lag_cnt[U];

  initial begin
    for (int i = 0; i < U; i++) begin
      run_cnt[i] = 0;
      lag_cnt[i] = 0;
    end
  end

  // Each cell raises done stub_dly cycles into a run and holds it until start
  // falls (plus stub_lag cycles); the word turns to junk after the first cycle.
  always @(negedge clk) begin
    for (int i = 0; i < U; i++) begin
      if (o_cell_start) begin
        lag_cnt[i] = 0;
        if (cell_done[i]) cell_word[i] = $urandom;
        else if (!stub_never[i] && run_cnt[i] == stub_dly[i]) begin
          cell_done[i] = 1'b1;
          cell_word[i] = o_cell_phase ? stub_h[i] : stub_r[i];
        end else run_cnt[i] = run_cnt[i] + 1;
      end else if (cell_done[i] && lag_cnt[i] < stub_lag[i]) begin
        lag_cnt[i]   = lag_cnt[i] + 1;
        cell_word[i] = $urandom;
      end else begin
        cell_done[i] = 1'b0;
        run_cnt[i]   = 0;
        lag_cnt[i]   = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (o_done) done_pulses = done_pulses + 1;
    if (o_cell_start && !o_cell_phase) p0_cycles = p0_cycles + 1;
  end

  // ---------------- reference arithmetic
  function automatic real f2r(input logic [31:0] a);
    logic [10:0] e;
    if (a[30:23] == 8'd0) return $bitstoreal({a[31], 63'd0});
    e = {3'b000, a[30:23]} + 11'd896;
    return $bitstoreal({a[31], e, a[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] d2f(input logic [63:0] d);
    int          e;
    logic [23:0] m;
    logic        up;
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e  = int'(d[62:52]) - 896;
    up = d[28] && ((d[27:0] != 28'd0) || d[29]);
    m  = {1'b0, d[51:29]} + {23'd0, up};
    if (m[23]) e = e + 1;
    return {d[63], e[7:0], m[22:0]};
  endfunction

  // The exact product of two singles fits in a double, so one rounding step is exact RNE.
  function automatic logic [31:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
    real p;
    p = f2r(a) * f2r(b);
    return d2f($realtobits(p));
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0]  e;
    logic [22:0] m;
    e = 8'($urandom_range(110, 140));
    m = 23'($urandom);
    return {1'($urandom_range(0, 1)), e, m};
  endfunction

  // ---------------- checking
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total = checks_total + 1;
    if (got === exp) checks_passed = checks_passed + 1;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // ---------------- driver tasks
  task automatic prep_step();
    for (int i = 0; i < U; i++) exp_q.push_back(fmul_ref(stub_r[i], h_model[i]));
    for (int i = 0; i < U; i++) begin
      exp_q.push_back(stub_h[i]);
      h_model[i] = stub_h[i];
    end
    step_model = step_model + 16'd1;
    exp_q.push_back({16'd0, step_model});
  endtask

  task automatic set_stubs(input bit random_vals);
    for (int i = 0; i < U; i++) begin
      if (random_vals) begin
        stub_r[i] = ($urandom_range(0, 5) == 0) ? FP_ZERO : rand_fp();
        stub_h[i] = rand_fp();
      end
      stub_dly[i]   = $urandom_range(0, 6);
      stub_lag[i]   = $urandom_range(0, 2);
      stub_never[i] = 1'b0;
    end
  endtask

  task automatic begin_step();
    logic [F*DW-1:0] xv;
    xv = {$urandom, $urandom, $urandom};
    @(negedge clk);
    in_vec  = xv;
    i_start = 1'b1;
    p0_base = p0_cycles;
    @(negedge clk);
    i_start = 1'b0;
    check_eq("busy_after_start", {31'd0, o_busy}, 32'd1);
    check_eq("error_cleared", {31'd0, o_error}, 32'd0);
    for (int i = 0; i < F; i++) check_eq("x_capture", o_in_vec[i*DW +: DW], xv[i*DW +: DW]);
  endtask

  task automatic finish_step();
    int c;
    c = 0;
    while (!o_done && c < 3000) begin
      @(negedge clk);
      c = c + 1;
    end
    if (!o_done) begin
      check_eq("done_timeout", {31'd0, o_done}, 32'd1);
      exp_q.delete();
      return;
    end
    for (int i = 0; i < U; i++) check_eq("r_mod", r_mod_w[i], exp_q.pop_front());
    @(negedge clk);
    done_exp = done_exp + 1;
    for (int i = 0; i < U; i++) begin
      logic [DW-1:0] e;
      e = exp_q.pop_front();
      check_eq("hidden", hidden_w[i], e);
      check_eq("prev_hidden", prev_w[i], e);
    end
    check_eq("step_count", {16'd0, o_step_count}, exp_q.pop_front());
    check_eq("idle_after_commit", {31'd0, o_busy}, 32'd0);
    check_eq("no_error", {31'd0, o_error}, 32'd0);
    check_eq("done_pulses", done_pulses, done_exp);
  endtask

  // ---------------- main sequence
  initial begin
    int c;
    rstn           = 1'b0;
    i_start        = 1'b0;
    i_clear_hidden = 1'b0;
    in_vec         = '0;
    step_model     = 16'd0;
    for (int i = 0; i < U; i++) h_model[i] = FP_ZERO;
    set_stubs(1'b1);
    repeat (3) @(negedge clk);
    check_eq("rst_busy", {31'd0, o_busy}, 32'd0);
    check_eq("rst_done", {31'd0, o_done}, 32'd0);
    check_eq("rst_error", {31'd0, o_error}, 32'd0);
    check_eq("rst_cell_start", {31'd0, o_cell_start}, 32'd0);
    check_eq("rst_step", {16'd0, o_step_count}, 32'd0);
    for (int i = 0; i < U; i++) check_eq("rst_hidden", hidden_w[i], FP_ZERO);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Step 1: zero hidden, r = 0.5 everywhere.
    set_stubs(1'b0);
    for (int i = 0; i < U; i++) stub_r[i] = 32'h3F00_0000;
    stub_h[0] = FP_ONE; stub_h[1] = 32'hC000_0000; stub_h[2] = 32'h3E80_0000;
    prep_step();
    begin_step();
    finish_step();
    for (int i = 0; i < U; i++) check_eq("t1_rmod_zero", r_mod_w[i], FP_ZERO);

    // Step 2: hidden {1,-2,0.25}, r {0.5,0.5,0}.
    set_stubs(1'b0);
    stub_r[0] = 32'h3F00_0000; stub_r[1] = 32'h3F00_0000; stub_r[2] = FP_ZERO;
    for (int i = 0; i < U; i++) stub_h[i] = rand_fp();
    prep_step();
    begin_step();
    finish_step();
    check_eq("t2_rmod0", r_mod_w[0], 32'h3F00_0000);
    check_eq("t2_rmod1", r_mod_w[1], 32'hBF80_0000);
    check_eq("t2_rmod2", r_mod_w[2], 32'h0000_0000);

    // Step 3: skewed done timing; start must stay high until the slowest cell.
    set_stubs(1'b1);
    stub_dly[0] = 7; stub_dly[1] = 20; stub_dly[2] = 1;
    prep_step();
    begin_step();
    finish_step();
    check_eq("t3_p0_start_cycles", p0_cycles - p0_base, 21);

    for (int n = 0; n < 8; n++) begin
      set_stubs(1'b1);
      prep_step();
      begin_step();
      finish_step();
    end

    // Clear and start together: clear wins, start is taken the next cycle.
    set_stubs(1'b1);
    @(negedge clk);
    in_vec         = {$urandom, $urandom, $urandom};
    i_clear_hidden = 1'b1;
    i_start        = 1'b1;
    @(negedge clk);
    check_eq("t6_busy_low", {31'd0, o_busy}, 32'd0);
    check_eq("t6_step_zero", {16'd0, o_step_count}, 32'd0);
    for (int i = 0; i < U; i++) check_eq("t6_hidden_zero", hidden_w[i], FP_ZERO);
    i_clear_hidden = 1'b0;
    step_model     = 16'd0;
    for (int i = 0; i < U; i++) h_model[i] = FP_ZERO;
    prep_step();
    @(negedge clk);
    check_eq("t6_started", {31'd0, o_busy}, 32'd1);
    i_start = 1'b0;
    finish_step();

    // Back-to-back: start held high gives exactly one idle cycle between steps.
    set_stubs(1'b1);
    for (int i = 0; i < U; i++) stub_lag[i] = 0;
    prep_step();
    prep_step();
    @(negedge clk);
    i_start = 1'b1;
    finish_step();
    @(negedge clk);
    check_eq("b2b_restart", {31'd0, o_busy}, 32'd1);
    i_start = 1'b0;
    finish_step();

    // Timeout: cell 1 never answers.
    set_stubs(1'b1);
    stub_never[1] = 1'b1;
    begin_step();
    c = 0;
    while (o_busy && c < 5000) begin
      @(negedge clk);
      c = c + 1;
    end
    check_eq("t4_returned_idle", {31'd0, o_busy}, 32'd0);
    check_eq("t4_error", {31'd0, o_error}, 32'd1);
    check_eq("t4_cell_start", {31'd0, o_cell_start}, 32'd0);
    check_eq("t4_wait_len", (c >= 4000 && c <= 4200) ? 32'd1 : 32'd0, 32'd1);
    stub_never[1] = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("t4_error_sticky", {31'd0, o_error}, 32'd1);
    check_eq("t4_step_kept", {16'd0, o_step_count}, {16'd0, step_model});
    check_eq("t4_no_done", done_pulses, done_exp);
    for (int i = 0; i < U; i++) check_eq("t4_hidden_kept", hidden_w[i], h_model[i]);
    set_stubs(1'b1);
    prep_step();
    begin_step();
    finish_step();

    // Asynchronous reset while the multiplier is running.
    set_stubs(1'b1);
    begin_step();
    c = 0;
    while (o_dbg_state != S_RMUL_WAIT && c < 300) begin
      @(negedge clk);
      c = c + 1;
    end
    check_eq("t5_reach_rmul_wait", {28'd0, o_dbg_state}, {28'd0, S_RMUL_WAIT});
    #1 rstn = 1'b0;
    #1;
    check_eq("t5_busy", {31'd0, o_busy}, 32'd0);
    check_eq("t5_cell_start", {31'd0, o_cell_start}, 32'd0);
    check_eq("t5_step", {16'd0, o_step_count}, 32'd0);
    check_eq("t5_xvec", o_in_vec[DW-1:0], 32'd0);
    for (int i = 0; i < U; i++) begin
      check_eq("t5_hidden", hidden_w[i], FP_ZERO);
      check_eq("t5_rmod", r_mod_w[i], FP_ZERO);
    end
    @(negedge clk);
    rstn       = 1'b1;
    step_model = 16'd0;
    for (int i = 0; i < U; i++) h_model[i] = FP_ZERO;
    repeat (3) @(negedge clk);
    set_stubs(1'b1);
    prep_step();
    begin_step();
    finish_step();

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
